// File: rtl/pronoc_flit_pkg.sv
// Shared flit-format helpers and FSM state type for the network-interface blocks.
package pronoc_flit_pkg;

    // Ceiling log2: smallest r with 2**r >= value (returns 0 for value <= 1).
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Head flag sits at the top of the flit.
    function automatic int head_pos(input int v, input int fpay);
        return fpay + v + 1;
    endfunction

    // Tail flag sits just below the head flag.
    function automatic int tail_pos(input int v, input int fpay);
        return fpay + v;
    endfunction

    // One-hot VC field occupies [vc_msb:vc_lsb], directly above the payload.
    function automatic int vc_msb(input int v, input int fpay);
        return fpay + v - 1;
    endfunction

    function automatic int vc_lsb(input int v, input int fpay);
        return fpay + (v * 0);
    endfunction

    // Injector FSM: IDLE emits heads (and single-flit packets), BODY streams data words.
    typedef enum logic {
        NI_IDLE = 1'b0,
        NI_BODY = 1'b1
    } ni_state_e;

endpackage

// File: rtl/ni_credit_counter.sv
// Per-VC credit counter tracking free slots in the router's input buffer.
module ni_credit_counter #(
    parameter int B  = 4,
    parameter int Cw = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [Cw-1:0] count,
    output logic          nonzero
);

    localparam logic [Cw-1:0] FULL = Cw'(B);

    logic [Cw-1:0] count_q;
    logic [Cw-1:0] count_d;

    // Next count: simultaneous inc/dec cancel; out-of-range moves saturate.
    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q != FULL)) begin
            count_d = count_q + 1'b1;
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register; reset restores a full buffer's worth of credit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= FULL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign nonzero = (count_q != '0);

    // A credit return beyond B or a send without credit means upstream/downstream disagree.
    a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
        !(inc && !dec && (count_q == FULL)));
    a_no_underflow : assert property (@(posedge clk) disable iff (!reset)
        !(dec && !inc && (count_q == '0)));

endmodule

// File: rtl/ni_flit_injector.sv
// NI injection stage: packs packet requests and data words into wormhole flits for
// the router's local port, with per-VC credit tracking and round-robin VC choice.
module ni_flit_injector
    import pronoc_flit_pkg::*;
#(
    parameter int V           = 4,
    parameter int B           = 4,
    parameter int NX          = 4,
    parameter int NY          = 4,
    parameter int Fpay        = 32,
    parameter int MAX_PKT_LEN = 16,
    localparam int Fw = 2 + V + Fpay,
    localparam int Xw = log2(NX),
    localparam int Yw = log2(NY),
    localparam int Lw = log2(MAX_PKT_LEN + 1),
    localparam int Cw = log2(B + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [Xw-1:0]   current_x,
    input  logic [Yw-1:0]   current_y,
    input  logic            pkt_req,
    input  logic [Xw-1:0]   pkt_dest_x,
    input  logic [Yw-1:0]   pkt_dest_y,
    input  logic [Lw-1:0]   pkt_len,
    output logic            pkt_ack,
    input  logic [Fpay-1:0] data_in,
    input  logic            data_valid,
    output logic            data_ready,
    output logic [Fw-1:0]   flit_out,
    output logic            flit_out_wr,
    input  logic [V-1:0]    credit_in,
    output logic            busy
);

    localparam int Vw     = (V > 1) ? log2(V) : 1;
    localparam int HEAD   = head_pos(V, Fpay);
    localparam int TAIL   = tail_pos(V, Fpay);
    localparam int VC_MSB = vc_msb(V, Fpay);
    localparam int VC_LSB = vc_lsb(V, Fpay);
    localparam int ADDR_W = 2 * (Xw + Yw);

    ni_state_e       state_q, state_d;
    logic [V-1:0]    vc_q, vc_d;
    logic [Vw-1:0]   rr_q, rr_d;
    logic [Lw-1:0]   rem_q, rem_d;
    logic [Fw-1:0]   flit_q, flit_d;
    logic            flit_wr_q, flit_wr_d;

    logic [V-1:0]    credit_dec;
    logic [V-1:0]    vc_nonzero;
    logic [Cw-1:0]   vc_count [V];
    logic            body_credit;
    logic            pick_found;
    logic [Vw-1:0]   pick_idx;
    logic [Fpay-1:0] head_payload;

    // One credit counter per VC; a registered flit consumes, credit_in returns.
    for (genvar gi = 0; gi < V; gi++) begin : g_credit
        ni_credit_counter #(
            .B  (B),
            .Cw (Cw)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .inc     (credit_in[gi]),
            .dec     (credit_dec[gi]),
            .count   (vc_count[gi]),
            .nonzero (vc_nonzero[gi])
        );
    end

    // Round-robin search for a VC with credit, starting just after the last grant.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_q;
        for (int i = 1; i <= V; i++) begin
            if (!pick_found && vc_nonzero[(int'(rr_q) + i) % V]) begin
                pick_found = 1'b1;
                pick_idx   = Vw'((int'(rr_q) + i) % V);
            end
        end
    end

    // Credit availability on the VC the current packet is locked to.
    always_comb begin
        body_credit = 1'b0;
        for (int v = 0; v < V; v++) begin
            if (vc_q[v] && (vc_count[v] != '0)) begin
                body_credit = 1'b1;
            end
        end
    end

    // Head payload: dest_x, dest_y, src_x, src_y packed from bit 0 upward.
    always_comb begin
        head_payload               = '0;
        head_payload[ADDR_W-1:0]   = {current_y, current_x, pkt_dest_y, pkt_dest_x};
    end

    // FSM next state, handshakes and the flit to register this cycle.
    always_comb begin
        state_d    = state_q;
        vc_d       = vc_q;
        rr_d       = rr_q;
        rem_d      = rem_q;
        flit_d     = flit_q;
        flit_wr_d  = 1'b0;
        credit_dec = '0;
        pkt_ack    = 1'b0;
        data_ready = 1'b0;
        if (reset) begin
            case (state_q)
                NI_IDLE: begin
                    pkt_ack = pkt_req && pick_found;
                    if (pkt_ack) begin
                        vc_d                   = V'(1) << pick_idx;
                        rr_d                   = pick_idx;
                        flit_wr_d              = 1'b1;
                        credit_dec             = V'(1) << pick_idx;
                        flit_d                 = '0;
                        flit_d[HEAD]           = 1'b1;
                        flit_d[VC_MSB:VC_LSB]  = V'(1) << pick_idx;
                        flit_d[Fpay-1:0]       = head_payload;
                        if (pkt_len <= Lw'(1)) begin
                            // Single-flit packet: head doubles as tail, no data consumed.
                            flit_d[TAIL] = 1'b1;
                            rem_d        = '0;
                        end else begin
                            rem_d   = pkt_len - Lw'(1);
                            state_d = NI_BODY;
                        end
                    end
                end
                NI_BODY: begin
                    data_ready = data_valid && body_credit;
                    if (data_ready) begin
                        flit_wr_d  = 1'b1;
                        credit_dec = vc_q;
                        flit_d     = {1'b0, (rem_q == Lw'(1)), vc_q, data_in};
                        rem_d      = rem_q - Lw'(1);
                        if (rem_q == Lw'(1)) begin
                            state_d = NI_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = NI_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= NI_IDLE;
            vc_q      <= '0;
            rr_q      <= Vw'(V - 1);
            rem_q     <= '0;
            flit_q    <= '0;
            flit_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vc_q      <= vc_d;
            rr_q      <= rr_d;
            rem_q     <= rem_d;
            flit_q    <= flit_d;
            flit_wr_q <= flit_wr_d;
        end
    end

    assign flit_out    = flit_q;
    assign flit_out_wr = flit_wr_q;
    assign busy        = (state_q == NI_BODY);

endmodule

// File: tb/tb_ni_flit_injector.sv
// Directed bench for ni_flit_injector: expected flits go into a scoreboard queue,
// an independent monitor pops and compares every flit the DUT writes.
module tb_ni_flit_injector;

    logic        clk;
    logic        reset;
    logic [1:0]  current_x;
    logic [1:0]  current_y;
    logic        pkt_req;
    logic [1:0]  pkt_dest_x;
    logic [1:0]  pkt_dest_y;
    logic [4:0]  pkt_len;
    logic        pkt_ack;
    logic [31:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [37:0] flit_out;
    logic        flit_out_wr;
    logic [3:0]  credit_in;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [37:0] exp_q [$];

    // Tile (1,2) sending to (3,0): dest_x=3, dest_y=0, src_x=1, src_y=2 -> 0b10_01_00_11.
    localparam logic [31:0] HEAD_PAY = 32'h0000_0093;

    ni_flit_injector dut (
        .clk         (clk),
        .reset       (reset),
        .current_x   (current_x),
        .current_y   (current_y),
        .pkt_req     (pkt_req),
        .pkt_dest_x  (pkt_dest_x),
        .pkt_dest_y  (pkt_dest_y),
        .pkt_len     (pkt_len),
        .pkt_ack     (pkt_ack),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .flit_out    (flit_out),
        .flit_out_wr (flit_out_wr),
        .credit_in   (credit_in),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [37:0] mk(input bit h, input bit t, input logic [3:0] vc,
                                       input logic [31:0] p);
        return {h, t, vc, p};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every written flit must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (flit_out_wr === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_flit: got %0h expected none", flit_out);
                end else begin
                    chk("flit", 64'(flit_out), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic do_reset();
        reset      = 1'b0;
        pkt_req    = 1'b0;
        data_valid = 1'b0;
        credit_in  = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Request a packet; expect an ack and a head flit on exp_vc.
    task automatic send_head(input int len, input logic [3:0] exp_vc);
        pkt_req = 1'b1;
        pkt_len = 5'(len);
        #1;
        chk("pkt_ack", 64'(pkt_ack), 64'd1);
        exp_q.push_back(mk(1'b1, (len <= 1), exp_vc, HEAD_PAY));
        $display("head len=%0d vc=%b", len, exp_vc);
        @(negedge clk);
        pkt_req = 1'b0;
    endtask

    // Offer a data word; expect it consumed as a body/tail flit on exp_vc.
    task automatic body(input logic [31:0] word, input bit tail, input logic [3:0] exp_vc);
        data_valid = 1'b1;
        data_in    = word;
        #1;
        chk("data_ready", 64'(data_ready), 64'd1);
        exp_q.push_back(mk(1'b0, tail, exp_vc, word));
        $display("body word=%0h tail=%0d vc=%b", word, tail, exp_vc);
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    // Offer a data word with credit exhausted; optionally return credit this cycle.
    task automatic stall(input logic [3:0] cred);
        data_valid = 1'b1;
        credit_in  = cred;
        #1;
        chk("stall_ready", 64'(data_ready), 64'd0);
        $display("stall credit_in=%b", cred);
        @(negedge clk);
        credit_in  = '0;
        data_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] five_vcs [5];
        five_vcs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        current_x  = 2'd1;
        current_y  = 2'd2;
        pkt_dest_x = 2'd3;
        pkt_dest_y = 2'd0;
        pkt_len    = 5'd3;
        data_in    = '0;
        credit_in  = '0;
        reset      = 1'b0;
        pkt_req    = 1'b1;
        data_valid = 1'b1;

        // Reset state, with requests held high during reset.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_flit_wr", 64'(flit_out_wr), 64'd0);
        chk("rst_flit", 64'(flit_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ack", 64'(pkt_ack), 64'd0);
        chk("rst_ready", 64'(data_ready), 64'd0);
        $display("reset state checked");
        pkt_req    = 1'b0;
        data_valid = 1'b0;
        reset      = 1'b1;
        @(negedge clk);

        // Three-flit packet on VC0.
        send_head(3, 4'b0001);
        #1;
        chk("s1_busy_body", 64'(busy), 64'd1);
        body(32'hA, 1'b0, 4'b0001);
        body(32'hB, 1'b1, 4'b0001);
        #1;
        chk("s1_busy_after_tail", 64'(busy), 64'd0);

        // Five back-to-back single-flit packets rotate through the VCs.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_head(1, five_vcs[i]);
        end

        // Six-flit packet with no credit return stalls after four flits.
        do_reset();
        send_head(6, 4'b0001);
        body(32'h11, 1'b0, 4'b0001);
        body(32'h12, 1'b0, 4'b0001);
        body(32'h13, 1'b0, 4'b0001);
        stall(4'b0000);
        stall(4'b0000);
        stall(4'b0001);
        body(32'h14, 1'b0, 4'b0001);
        stall(4'b0001);
        body(32'h15, 1'b1, 4'b0001);
        #1;
        chk("s3_busy_done", 64'(busy), 64'd0);

        // Credit returned while sending on the same VC keeps the count at 3.
        do_reset();
        send_head(15, 4'b0001);
        credit_in = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            body(32'h100 + 32'(i), 1'b0, 4'b0001);
        end
        credit_in = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            body(32'h200 + 32'(i), 1'b0, 4'b0001);
        end
        stall(4'b0001);
        body(32'h300, 1'b1, 4'b0001);

        // Reset mid-packet after two of five flits.
        do_reset();
        send_head(5, 4'b0001);
        body(32'h51, 1'b0, 4'b0001);
        reset      = 1'b0;
        data_valid = 1'b1;
        pkt_req    = 1'b1;
        #1;
        chk("midrst_ready", 64'(data_ready), 64'd0);
        chk("midrst_ack", 64'(pkt_ack), 64'd0);
        @(negedge clk);
        #1;
        chk("midrst_flit_wr", 64'(flit_out_wr), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        $display("reset mid-packet checked");
        reset      = 1'b1;
        data_valid = 1'b0;
        pkt_req    = 1'b0;
        send_head(5, 4'b0001);
        body(32'h61, 1'b0, 4'b0001);
        body(32'h62, 1'b0, 4'b0001);
        body(32'h63, 1'b0, 4'b0001);
        stall(4'b0001);
        body(32'h64, 1'b1, 4'b0001);

        // Drain every credit, then a request waits until one VC gets credit back.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_head(1, 4'b0001 << (i % 4));
        end
        pkt_req = 1'b1;
        pkt_len = 5'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("nocred_ack", 64'(pkt_ack), 64'd0);
            @(negedge clk);
        end
        credit_in = 4'b0100;
        #1;
        chk("cred_cycle_ack", 64'(pkt_ack), 64'd0);
        @(negedge clk);
        credit_in = 4'b0000;
        send_head(1, 4'b0100);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
